hmmm_loader: RTL

HMMM_LOADER -- requirements
Module: hmmm_loader

---
 rtl/hmmm_pkg.sv | 16 +
 rtl/hmmm_io_fifo.sv | 66 ++++++
 rtl/hmmm_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hmmm_pkg.sv
// Shared widths and loader state encoding for the HMMM program loader.
package hmmm_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } loader_state_t;

endpackage

// File: rtl/hmmm_io_fifo.sv
// Synchronous FIFO holding CPU read data; a push while full succeeds when a pop lands in the same cycle.
module hmmm_io_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    assign o_head  = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hmmm_loader.sv
// Streams a program into the HMMM CPU via address/data strobes, boots it, then
// services its bus reads (from an input FIFO), writes and halt.
module hmmm_loader
    import hmmm_pkg::*;
#(
    parameter int unsigned MAX_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              prog_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              cpu_rst,
    output logic              pgrm_addr,
    output logic              pgrm_data,
    output logic [WORD_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [WORD_W-1:0] bus_in,
    input  logic              read,
    input  logic              write,
    input  logic              halt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
    localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH + 1);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_word;
    logic              r_last;
    logic              r_done;
    logic              r_err;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;

    logic              w_prog_ready;
    logic              w_pgrm_addr;
    logic              w_pgrm_data;
    logic              w_bus_oe;
    logic [WORD_W-1:0] w_bus_out;
    logic              w_pop;
    logic              w_push;
    logic [WORD_W-1:0] w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    // in_ready also rises while full if a CPU read frees a slot this cycle
    assign in_ready = !w_fifo_full || w_pop;
    assign w_push   = in_valid && in_ready;

    hmmm_io_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_prog_ready = 1'b0;
        w_pgrm_addr  = 1'b0;
        w_pgrm_data  = 1'b0;
        w_bus_oe     = 1'b0;
        w_bus_out    = '0;
        w_pop        = 1'b0;
        unique case (r_state)
            ST_ADDR: begin
                w_prog_ready = 1'b1;
                if (prog_valid) begin
                    w_pgrm_addr = 1'b1;
                    w_bus_oe    = 1'b1;
                    w_bus_out   = {{(WORD_W - ADDR_W){1'b0}}, r_addr};
                end
            end
            ST_DATA: begin
                w_pgrm_data = 1'b1;
                w_bus_oe    = 1'b1;
                w_bus_out   = r_word;
            end
            ST_RUN: begin
                if (!halt && read) begin
                    w_bus_oe  = 1'b1;
                    w_bus_out = w_fifo_empty ? '0 : w_fifo_head;
                    w_pop     = !w_fifo_empty;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state <= ST_ADDR;
                        r_addr  <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (prog_valid) begin
                        r_word <= prog_data;
                        r_last <= prog_last;
                        if (!prog_last && r_addr == LAST_ADDR) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_addr != LAST_ADDR) begin
                        r_addr <= r_addr + 1'b1;
                    end
                    r_state <= r_last ? ST_BOOT : ST_ADDR;
                end
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt) begin
                        r_state <= ST_HALTED;
                        r_done  <= 1'b1;
                    end else begin
                        if (read && w_fifo_count == '0) begin
                            r_err <= 1'b1;
                        end
                        if (write) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= bus_in;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign prog_ready = w_prog_ready;
    assign pgrm_addr  = w_pgrm_addr;
    assign pgrm_data  = w_pgrm_data;
    assign bus_oe     = w_bus_oe;
    assign bus_out    = w_bus_out;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign cpu_rst    = (r_state == ST_IDLE) || (r_state == ST_BOOT);
    assign busy       = (r_state == ST_ADDR) || (r_state == ST_DATA) ||
                        (r_state == ST_BOOT) || (r_state == ST_RUN);
    assign done       = r_done;
    assign err        = r_err;

endmodule
